ibus_responder: RTL and testbench

IBUS_RESPONDER -- requirements
Module: ibus_responder

---
 rtl/ibus_responder_pkg.sv | 38 +++
 rtl/ibus_rom64.sv | 33 +++
 rtl/ibus_responder.sv | 125 ++++++++++++
 tb/tb_ibus_responder.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ibus_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ibus_responder_pkg
// Purpose  : Shared types and constants for the instruction-bus responder:
//            request/response structs, FSM state encoding, NOP fill word.
// Revision : 1.0  initial release
// ============================================================================
package ibus_responder_pkg;

  // Fetch-side request: a valid strobe plus the full 64-bit byte address.
  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
  } ibus_req_t;

  // Responder-side reply: handshake on the address phase, data phase strobe
  // and the selected 32-bit instruction half-word.
  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;

  // Transaction FSM: idle, counting down the latency, presenting data.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } ibus_state_e;

  // Returned for any fetch that cannot be served (RISC-V addi x0,x0,0).
  localparam logic [31:0] c_nop_instr = 32'h0000_0013;

  // Latency counter width; holds LATENCY-1 for LATENCY up to 15.
  localparam int c_cnt_w = 4;

endpackage : ibus_responder_pkg
`default_nettype wire

// File: rtl/ibus_rom64.sv
`default_nettype none
// ============================================================================
// Module   : ibus_rom64
// Purpose  : DEPTH x 64-bit backing store with one asynchronous read port
//            and one synchronous write (preload) port. Not reset.
// Revision : 1.0  initial release
// ============================================================================
module ibus_rom64 #(
  parameter int DEPTH = 4096,
  parameter int IDX_W = 12
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_widx,
  input  logic [63:0]      i_wdata,
  input  logic [IDX_W-1:0] i_ridx,
  output logic [63:0]      o_rdata
);

  logic [63:0] r_mem [DEPTH];

  // Preload write; indices past the end of a non-power-of-two store are dropped.
  always_ff @(posedge clk) begin
    if (i_we && (int'(i_widx) < DEPTH)) begin
      r_mem[i_widx] <= i_wdata;
    end
  end

  // Asynchronous read: a same-cycle write is only visible after the edge.
  assign o_rdata = r_mem[i_ridx];

endmodule : ibus_rom64
`default_nettype wire

// File: rtl/ibus_responder.sv
`default_nettype none
// ============================================================================
// Module   : ibus_responder
// Purpose  : Fixed-latency instruction-fetch responder. Accepts one request
//            at a time, waits LATENCY cycles, then returns the addressed
//            32-bit half of a 64-bit backing-store word (or a NOP with err
//            for misaligned / out-of-range addresses).
// Revision : 1.0  initial release
// ============================================================================
module ibus_responder
  import ibus_responder_pkg::*;
#(
  parameter int          LATENCY = 2,              // legal range 1..15
  parameter int          DEPTH   = 4096,           // 64-bit words in store
  parameter logic [63:0] BASE    = 64'h8000_0000,  // byte address of word 0
  localparam int         IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  ibus_req_t        ireq,
  output ibus_resp_t       iresp,
  input  logic             ld_en,
  input  logic [IDX_W-1:0] ld_idx,
  input  logic [63:0]      ld_data,
  output logic             err
);

  localparam logic [c_cnt_w-1:0] c_cnt_init = c_cnt_w'(LATENCY - 1);

  ibus_state_e        r_state;
  logic [c_cnt_w-1:0] r_cnt;
  logic [63:0]        r_addr;

  logic               w_addr_ok;
  logic               w_accept;
  logic               w_resp;
  logic [63:0]        w_off;
  logic               w_below;
  logic               w_beyond;
  logic               w_misalign;
  logic               w_bad;
  logic [IDX_W-1:0]   w_rd_idx;
  logic [63:0]        w_rd_word;
  logic               w_unused;

  // The address phase is open in IDLE and RESP (back-to-back), never in reset.
  assign w_addr_ok = ireq.valid && !reset && ((r_state == IDLE) || (r_state == RESP));
  assign w_accept  = ireq.valid && w_addr_ok;

  // Data phase is suppressed during reset so an aborted transfer never completes.
  assign w_resp = (r_state == RESP) && !reset;

  // Address decode of the latched request.
  assign w_off      = r_addr - BASE;
  assign w_below    = (r_addr < BASE);
  assign w_beyond   = (w_off[63:3] >= 61'(DEPTH));
  assign w_misalign = (r_addr[1:0] != 2'b00);
  assign w_bad      = w_below || w_beyond || w_misalign;

  // Bad addresses never drive the store; index 0 is a harmless stand-in.
  assign w_rd_idx = w_bad ? '0 : w_off[IDX_W+2:3];

  // Byte offset within the word is taken from the raw address instead.
  assign w_unused = ^w_off[2:0];

  ibus_rom64 #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_rom (
    .clk     (clk),
    .i_we    (ld_en),
    .i_widx  (ld_idx),
    .i_wdata (ld_data),
    .i_ridx  (w_rd_idx),
    .o_rdata (w_rd_word)
  );

  // Transaction FSM with latency counter and latched request address.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
    end else begin
      case (r_state)
        IDLE, RESP: begin
          if (w_accept) begin
            r_addr  <= ireq.addr;
            r_cnt   <= c_cnt_init;
            r_state <= (LATENCY == 1) ? RESP : WAIT;
          end else begin
            r_state <= IDLE;
          end
        end
        WAIT: begin
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == c_cnt_w'(1)) begin
            r_state <= RESP;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Response mux: data and err are held at zero outside the data phase.
  always_comb begin
    iresp         = '0;
    err           = 1'b0;
    iresp.addr_ok = w_addr_ok;
    if (w_resp) begin
      iresp.data_ok = 1'b1;
      if (w_bad) begin
        iresp.data = c_nop_instr;
        err        = 1'b1;
      end else begin
        iresp.data = r_addr[2] ? w_rd_word[63:32] : w_rd_word[31:0];
      end
    end
  end

endmodule : ibus_responder
`default_nettype wire

// File: tb/tb_ibus_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_ibus_responder
// Purpose  : Self-checking bench for ibus_responder. Three instances with
//            LATENCY 1, 2 and 3 share the preload port; a scoreboard queue
//            holds expected responses (dut, cycle, data, err).
// Revision : 1.0  initial release
// ============================================================================
module tb_ibus_responder;
  import ibus_responder_pkg::*;

  localparam logic [63:0] BASE  = 64'h8000_0000;
  localparam int          DEPTH = 4096;

  typedef struct {
    int          dut;
    int          cyc;
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ld_en = 1'b0;
  logic [11:0] ld_idx = '0;
  logic [63:0] ld_data = '0;
  ibus_req_t   req  [3];
  ibus_resp_t  resp [3];
  logic        errw [3];

  logic [63:0] mdl [DEPTH];
  exp_t        sbq [$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  bit          mon_en = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ibus_responder #(.LATENCY(1), .DEPTH(DEPTH), .BASE(BASE)) u_lat1 (
    .clk(clk), .reset(reset), .ireq(req[0]), .iresp(resp[0]),
    .ld_en(ld_en), .ld_idx(ld_idx), .ld_data(ld_data), .err(errw[0]));
  ibus_responder #(.LATENCY(2), .DEPTH(DEPTH), .BASE(BASE)) u_lat2 (
    .clk(clk), .reset(reset), .ireq(req[1]), .iresp(resp[1]),
    .ld_en(ld_en), .ld_idx(ld_idx), .ld_data(ld_data), .err(errw[1]));
  ibus_responder #(.LATENCY(3), .DEPTH(DEPTH), .BASE(BASE)) u_lat3 (
    .clk(clk), .reset(reset), .ireq(req[2]), .iresp(resp[2]),
    .ld_en(ld_en), .ld_idx(ld_idx), .ld_data(ld_data), .err(errw[2]));

  function automatic int lat_of(input int k);
    return k + 1;
  endfunction

  // Reference behaviour of a fetch from the bench's own copy of the store.
  function automatic void model(input logic [63:0] a, output logic [31:0] d, output logic e);
    logic [63:0] off;
    off = a - BASE;
    if ((a[1:0] != 2'b00) || (a < BASE) || ((off >> 3) >= 64'(DEPTH))) begin
      d = 32'h0000_0013;
      e = 1'b1;
    end else begin
      d = a[2] ? mdl[int'(off >> 3)][63:32] : mdl[int'(off >> 3)][31:0];
      e = 1'b0;
    end
  endfunction

  // Scoreboard monitor: every data_ok must match the queue head exactly.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      for (int k = 0; k < 3; k++) begin
        if (resp[k].data_ok === 1'b1) begin
          checks++;
          if (sbq.size() == 0 || sbq[0].dut != k) begin
            errors++;
            $display("FAIL unexpected_resp dut%0d cyc %0d got data %h err %b, required none", k, cyc, resp[k].data, errw[k]);
          end else begin
            e = sbq.pop_front();
            if (resp[k].data !== e.data || errw[k] !== e.err || cyc != e.cyc) begin
              errors++;
              $display("FAIL resp dut%0d got data %h err %b cyc %0d, required data %h err %b cyc %0d",
                       k, resp[k].data, errw[k], cyc, e.data, e.err, e.cyc);
            end
          end
        end else begin
          checks++;
          if (resp[k].data_ok !== 1'b0 || resp[k].data !== 32'h0 || errw[k] !== 1'b0) begin
            errors++;
            $display("FAIL quiet_outputs dut%0d cyc %0d got data_ok %b data %h err %b, required 0 0 0",
                     k, cyc, resp[k].data_ok, resp[k].data, errw[k]);
          end
        end
      end
    end
  end

  task automatic load(input int idx, input logic [63:0] d);
    ld_en = 1'b1; ld_idx = 12'(idx); ld_data = d;
    @(posedge clk); #1;
    ld_en = 1'b0;
    mdl[idx] = d;
  endtask

  // Raise a request, wait (bounded) for addr_ok, optionally enqueue its response.
  task automatic send(input int k, input logic [63:0] a, input bit expect_it, output int acc);
    exp_t e;
    int   n;
    req[k].valid = 1'b1;
    req[k].addr  = a;
    n = 0;
    @(negedge clk);
    while (resp[k].addr_ok !== 1'b1 && n < 20) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (resp[k].addr_ok !== 1'b1) begin
      errors++;
      $display("FAIL addr_ok_timeout dut%0d addr %h got %b, required 1", k, a, resp[k].addr_ok);
    end
    acc = cyc;
    if (expect_it) begin
      e.dut = k;
      e.cyc = cyc + lat_of(k);
      model(a, e.data, e.err);
      sbq.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 40) begin
      n++;
      @(posedge clk); #1;
    end
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout got %0d pending, required 0", sbq.size());
      sbq.delete();
    end
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      req[k].valid = 1'b1;
      req[k].addr  = BASE;
    end
    repeat (3) @(posedge clk);
    mon_en = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (resp[k].addr_ok !== 1'b0 || resp[k].data_ok !== 1'b0 || resp[k].data !== 32'h0 || errw[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset_outputs dut%0d got %b %b %h %b, required 0 0 0 0",
                 k, resp[k].addr_ok, resp[k].data_ok, resp[k].data, errw[k]);
      end
      req[k].valid = 1'b0;
    end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_basic();
    int t0, acc;
    t0 = cyc;
    send(1, 64'h8000_0004, 1'b1, acc);
    req[1].valid = 1'b0;
    checks++;
    if (acc != t0) begin
      errors++;
      $display("FAIL basic_same_cycle_accept got cyc %0d, required %0d", acc, t0);
    end
    drain();
  endtask

  task automatic test_idle();
    req[1].valid = 1'b0;
    req[1].addr  = 64'h8000_0008;
    repeat (4) begin
      @(negedge clk);
      checks++;
      if (resp[1].addr_ok !== 1'b0) begin
        errors++;
        $display("FAIL idle_addr_ok got %b, required 0", resp[1].addr_ok);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int a0, a1, a2;
    send(0, 64'h8000_0000, 1'b1, a0);
    send(0, 64'h8000_0004, 1'b1, a1);
    req[0].valid = 1'b0;
    checks++;
    if (a1 - a0 != 1) begin
      errors++;
      $display("FAIL b2b_lat1_spacing got %0d, required 1", a1 - a0);
    end
    drain();
    send(1, 64'h8000_0000, 1'b1, a0);
    send(1, 64'h8000_000C, 1'b1, a1);
    send(1, 64'h8000_0010, 1'b1, a2);
    req[1].valid = 1'b0;
    checks++;
    if (a1 - a0 != 2 || a2 - a1 != 2) begin
      errors++;
      $display("FAIL b2b_lat2_spacing got %0d %0d, required 2 2", a1 - a0, a2 - a1);
    end
    drain();
  endtask

  task automatic test_errors();
    int acc;
    send(1, 64'h8000_0002, 1'b1, acc);
    send(1, BASE + 64'(8 * DEPTH), 1'b1, acc);
    send(1, 64'h7FFF_FFFC, 1'b1, acc);
    send(1, BASE + 64'(8 * (DEPTH - 1)) + 64'h4, 1'b1, acc);
    send(1, 64'h8000_0001, 1'b1, acc);
    req[1].valid = 1'b0;
    drain();
  endtask

  task automatic test_wait_change();
    int acc;
    send(2, 64'h8000_0008, 1'b1, acc);
    req[2].addr = 64'h8000_0000;
    @(negedge clk);
    checks++;
    if (resp[2].addr_ok !== 1'b0) begin
      errors++;
      $display("FAIL wait_addr_ok_1 got %b, required 0", resp[2].addr_ok);
    end
    @(posedge clk); #1;
    req[2].addr = 64'h8000_0012;
    @(negedge clk);
    checks++;
    if (resp[2].addr_ok !== 1'b0) begin
      errors++;
      $display("FAIL wait_addr_ok_2 got %b, required 0", resp[2].addr_ok);
    end
    @(posedge clk); #1;
    req[2].valid = 1'b0;
    drain();
  endtask

  task automatic test_same_cycle_write();
    int acc;
    send(0, 64'h8000_0010, 1'b1, acc);
    req[0].valid = 1'b0;
    ld_en = 1'b1; ld_idx = 12'd2; ld_data = 64'h5555_AAAA_3333_CCCC;
    @(posedge clk); #1;
    ld_en = 1'b0;
    mdl[2] = 64'h5555_AAAA_3333_CCCC;
    drain();
    send(0, 64'h8000_0014, 1'b1, acc);
    req[0].valid = 1'b0;
    drain();
  endtask

  task automatic test_reset_abort();
    int acc;
    send(1, 64'h8000_0004, 1'b0, acc);
    reset = 1'b1;
    req[1].valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    send(0, 64'h8000_0008, 1'b0, acc);
    reset = 1'b1;
    req[0].valid = 1'b0;
    @(negedge clk);
    checks++;
    if (resp[0].data_ok !== 1'b0) begin
      errors++;
      $display("FAIL abort_in_resp got data_ok %b, required 0", resp[0].data_ok);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    send(1, 64'h8000_0004, 1'b1, acc);
    req[1].valid = 1'b0;
    drain();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog_timeout got cyc %0d, required finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 3; k++) begin
      req[k].valid = 1'b0;
      req[k].addr  = '0;
    end
    #1;
    test_reset();
    load(0, 64'h0050_0093_0010_0013);
    load(1, 64'h0030_0193_0020_0113);
    load(2, 64'h1111_1111_2222_2222);
    load(DEPTH - 1, 64'hABCD_0123_4567_890F);
    test_basic();
    test_idle();
    test_back_to_back();
    test_errors();
    test_wait_change();
    test_same_cycle_write();
    test_reset_abort();
    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_ibus_responder
`default_nettype wire
